// File: rtl/nvdla_sdp_mrdma_eg_pkg.sv
// nvdla_sdp_mrdma_eg_pkg: shared constants and types for the SDP MRDMA egress
// cq tracker. Holds the context-queue entry layout, the entry width and the
// tracker state encoding.
package nvdla_sdp_mrdma_eg_pkg;

    // Context queue entry layout: [11:0] beat_cnt_m1, [12] last_surf, [13] last_layer
    localparam int unsigned CQ_W           = 14;
    localparam int unsigned BEAT_CNT_LSB   = 0;
    localparam int unsigned BEAT_CNT_MSB   = 11;
    localparam int unsigned LAST_SURF_BIT  = 12;
    localparam int unsigned LAST_LAYER_BIT = 13;

    localparam int unsigned PERF_W         = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } eg_state_e;

endpackage

// File: rtl/nvdla_sdp_mrdma_eg_cq_tracker_if.sv
// nvdla_sdp_mrdma_eg_cq_tracker_if: bundle of the tracker's handshake and bus
// signals (cq pop, DMA read response, credit return, output beat, layer_done,
// perf counter). slave = tracker view, master = environment view.
interface nvdla_sdp_mrdma_eg_cq_tracker_if #(
    parameter int unsigned DW = 512
);
    logic                                   cq2eg_pvld;
    logic                                   cq2eg_prdy;
    logic [nvdla_sdp_mrdma_eg_pkg::CQ_W-1:0] cq2eg_pd;

    logic                                   dma_rd_rsp_pvld;
    logic                                   dma_rd_rsp_prdy;
    logic [DW-1:0]                          dma_rd_rsp_pd;
    logic                                   dma_rd_cdt_lat_fifo_pop;

    logic                                   eg_out_pvld;
    logic                                   eg_out_prdy;
    logic [DW-1:0]                          eg_out_pd;
    logic                                   eg_out_last_surf;
    logic                                   eg_out_last_layer;

    logic                                   layer_done;
    logic                                   perf_clr;
    logic [nvdla_sdp_mrdma_eg_pkg::PERF_W-1:0] perf_stall_cnt;

    modport slave (
        input  cq2eg_pvld, cq2eg_pd,
        input  dma_rd_rsp_pvld, dma_rd_rsp_pd,
        input  eg_out_prdy, perf_clr,
        output cq2eg_prdy, dma_rd_rsp_prdy, dma_rd_cdt_lat_fifo_pop,
        output eg_out_pvld, eg_out_pd, eg_out_last_surf, eg_out_last_layer,
        output layer_done, perf_stall_cnt
    );

    modport master (
        output cq2eg_pvld, cq2eg_pd,
        output dma_rd_rsp_pvld, dma_rd_rsp_pd,
        output eg_out_prdy, perf_clr,
        input  cq2eg_prdy, dma_rd_rsp_prdy, dma_rd_cdt_lat_fifo_pop,
        input  eg_out_pvld, eg_out_pd, eg_out_last_surf, eg_out_last_layer,
        input  layer_done, perf_stall_cnt
    );

endinterface

// File: rtl/nvdla_sdp_mrdma_eg_pipe.sv
// nvdla_sdp_mrdma_eg_pipe: single-register valid/ready slice.
// Ports: clk, rst (sync, active-high); in_vld/in_rdy_c/in_pd upstream;
// out_vld/out_rdy/out_pd downstream. in_rdy_c is combinational.
module nvdla_sdp_mrdma_eg_pipe #(
    parameter int unsigned W = 514
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy_c,
    input  logic [W-1:0] in_pd,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_pd
);

    // Accept when empty or when the held beat leaves this cycle.
    assign in_rdy_c = !out_vld || out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_pd  <= '0;
        end else if (in_vld && in_rdy_c) begin
            out_vld <= 1'b1;
            out_pd  <= in_pd;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/nvdla_sdp_mrdma_eg_cq_tracker.sv
// nvdla_sdp_mrdma_eg_cq_tracker: pops one cq context per read command, counts
// returning DMA read-response beats against it, tags the final beat with the
// entry's surface/layer end flags and forwards beats through a register slice.
// Ports: nvdla_core_clk, nvdla_core_rst (sync, active-high), eg (slave view of
// cq pop, read response, credit pop, output beat, layer_done, perf counter).
// Optional: NVDLA_SDP_MRDMA_EG_PERF_EN enables the saturating stall counter.
module nvdla_sdp_mrdma_eg_cq_tracker
    import nvdla_sdp_mrdma_eg_pkg::*;
#(
    parameter int unsigned DW    = 512,
    parameter int unsigned CNT_W = 12
) (
    input  logic                                 nvdla_core_clk,
    input  logic                                 nvdla_core_rst,
    nvdla_sdp_mrdma_eg_cq_tracker_if.slave       eg
);

    localparam int unsigned PW = DW + 2;

    eg_state_e         state;
    eg_state_e         state_nxt;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beat_cnt_nxt;
    logic              ctx_last_surf;
    logic              ctx_last_surf_nxt;
    logic              ctx_last_layer;
    logic              ctx_last_layer_nxt;

    logic              pipe_in_rdy;
    logic              rsp_acc;
    logic              beat_final;
    logic              out_vld;
    logic [PW-1:0]     out_pd;
    logic [PW-1:0]     pipe_in_pd;
    logic              layer_done_q;

    assign beat_final = (beat_cnt == '0);

    // No beat is taken while reset is asserted so no credit escapes.
    assign eg.dma_rd_rsp_prdy         = (state == RUN) && !nvdla_core_rst && pipe_in_rdy;
    assign rsp_acc                    = eg.dma_rd_rsp_pvld && eg.dma_rd_rsp_prdy;
    assign eg.dma_rd_cdt_lat_fifo_pop = rsp_acc;

    // Pop in IDLE, or chain the next context on the final beat of the current one.
    assign eg.cq2eg_prdy = (state == IDLE) || (rsp_acc && beat_final);

    // Next-state / context load.
    always_comb begin
        state_nxt          = state;
        beat_cnt_nxt       = beat_cnt;
        ctx_last_surf_nxt  = ctx_last_surf;
        ctx_last_layer_nxt = ctx_last_layer;
        unique case (state)
            IDLE: begin
                if (eg.cq2eg_pvld) begin
                    state_nxt          = RUN;
                    beat_cnt_nxt       = CNT_W'(eg.cq2eg_pd[BEAT_CNT_MSB:BEAT_CNT_LSB]);
                    ctx_last_surf_nxt  = eg.cq2eg_pd[LAST_SURF_BIT];
                    ctx_last_layer_nxt = eg.cq2eg_pd[LAST_LAYER_BIT];
                end
            end
            RUN: begin
                if (rsp_acc) begin
                    if (beat_final) begin
                        if (eg.cq2eg_pvld) begin
                            beat_cnt_nxt       = CNT_W'(eg.cq2eg_pd[BEAT_CNT_MSB:BEAT_CNT_LSB]);
                            ctx_last_surf_nxt  = eg.cq2eg_pd[LAST_SURF_BIT];
                            ctx_last_layer_nxt = eg.cq2eg_pd[LAST_LAYER_BIT];
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        beat_cnt_nxt = beat_cnt - CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            ctx_last_surf  <= 1'b0;
            ctx_last_layer <= 1'b0;
        end else begin
            state          <= state_nxt;
            beat_cnt       <= beat_cnt_nxt;
            ctx_last_surf  <= ctx_last_surf_nxt;
            ctx_last_layer <= ctx_last_layer_nxt;
        end
    end

    // Output slice payload: {last_layer, last_surf, data}.
    assign pipe_in_pd = {beat_final && ctx_last_layer, beat_final && ctx_last_surf, eg.dma_rd_rsp_pd};

    nvdla_sdp_mrdma_eg_pipe #(.W(PW)) u_pipe (
        .clk      (nvdla_core_clk),
        .rst      (nvdla_core_rst),
        .in_vld   (rsp_acc),
        .in_rdy_c (pipe_in_rdy),
        .in_pd    (pipe_in_pd),
        .out_vld  (out_vld),
        .out_rdy  (eg.eg_out_prdy),
        .out_pd   (out_pd)
    );

    assign eg.eg_out_pvld       = out_vld;
    assign eg.eg_out_pd         = out_pd[DW-1:0];
    assign eg.eg_out_last_surf  = out_pd[DW];
    assign eg.eg_out_last_layer = out_pd[DW+1];

    // Pulse the cycle after the layer's final beat leaves.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            layer_done_q <= 1'b0;
        end else begin
            layer_done_q <= out_vld && eg.eg_out_prdy && out_pd[DW+1];
        end
    end
    assign eg.layer_done = layer_done_q;

`ifdef NVDLA_SDP_MRDMA_EG_PERF_EN
    logic [PERF_W-1:0] perf_cnt;

    // Saturating downstream-stall counter; clear wins over increment.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || eg.perf_clr) begin
            perf_cnt <= '0;
        end else if (out_vld && !eg.eg_out_prdy && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + PERF_W'(1);
        end
    end
    assign eg.perf_stall_cnt = perf_cnt;
`else
    logic unused_perf_clr;
    assign unused_perf_clr   = eg.perf_clr;
    assign eg.perf_stall_cnt = '0;
`endif

endmodule
